// File: rtl/click_pkg.sv
// Shared definitions for the click-pipeline clocked endpoints: FSM encodings and
// an elaboration-time ceil(log2) helper.
package click_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } click_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/click_sync_sink_sync_ff_chain.sv
// Bit synchronizer for the two-phase drive toggle; all stages clear to 0 on reset
// so the chain agrees with the async side holding drive low during reset.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic d,
  output logic q,
  input  logic clk,
  input  logic rstn
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/click_sync_sink.sv
// Clocked sink for a two-phase click pipeline: synchronizes the drive toggle, buffers
// bundled words in a FWFT FIFO and returns a free toggle only when a slot is taken.
module click_sync_sink
  import click_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_drive,
  input  logic [DATA_W-1:0]       i_data,
  output logic                    o_free,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_data,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_stall
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              req_s;
  logic              pending;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              free_q;
  logic              valid_q;
  logic              full_q;
  click_state_t      state_q;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .d    (i_drive),
    .q    (req_s),
    .clk  (clk),
    .rstn (rstn)
  );

  // A token is outstanding while the synchronized request and our ack disagree.
  // Admission looks only at the registered full flag, so a same-cycle pop never
  // lets a push into a full FIFO; in S_STALL pending is always true.
  always_comb begin
    pending = req_s ^ free_q;
    push    = pending & ~full_q;
    pop     = valid_q & i_ready;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      free_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (pending && full_q) state_q <= S_STALL;
        S_STALL: if (!full_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        free_q   <= ~free_q;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage carries no reset; stale contents are masked by o_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_free  = free_q;
  assign o_valid = valid_q;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_stall = (state_q == S_STALL);

endmodule
